alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter STAT_W, default 32: width of statistics counters (used only with ALU_STAT_EN).
REQ-002 SHALL have one clock, clk; reset is asynchronous and active-high, named rst.
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 rdy  in  1  global enable; low = freeze all state.
REQ-006 rollback  in  1  mispredict flush from ROB.
REQ-007 in_config  in  1  issue valid from reservation station.
REQ-008 in_value_1 / in_value_2  in  32 each  rs1 / rs2 operands.
REQ-009 in_value_pc  in  32  instruction PC.
REQ-010 in_opcode  in  7  instr[6:0]; in_precise  in  3  funct3; in_more_precise  in  1  instr[30].
REQ-011 in_imm  in  32  sign-extended immediate (U-type already shifted); in_rob_entry  in  4  ROB tag.
REQ-012 out_config  out  1  result valid broadcast (to RS, LSB, ROB).
REQ-013 out_val  out  32  result value; out_rob_entry  out  4  tag.
REQ-014 out_jump  out  1  control transfer taken; out_target  out  32  next PC for control ops.
REQ-015 stat_ops / stat_taken  out  STAT_W each  present only with ALU_STAT_EN.

Function
REQ-016 Latency SHALL be exactly 1 cycle: operands accepted on edge N appear on outputs after edge N; out_config high for exactly one cycle per accepted op.
REQ-017 Accept condition: rdy && !rollback && in_config; no backpressure, one op per cycle, back-to-back supported.
REQ-018 Edge with rdy && !accept: out_config<=0, other outputs hold.
REQ-019 rdy low: all registers hold (including out_config).
REQ-020 rollback with rdy high: out_config<=0, input that cycle discarded.
REQ-021 LUI (0110111): val=imm, jump=0.  AUIPC (0010111): val=pc+imm, jump=0.
REQ-022 JAL (1101111): val=pc+4, jump=1, target=pc+imm.  JALR (1100111): val=pc+4, jump=1, target=(v1+imm)&~1.
REQ-023 BRANCH (1100011): funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE (signed), 110 BLTU, 111 BGEU (unsigned); val=0; jump=cond; target=pc+imm if taken else pc+4; funct3 010/011 -> not taken.
REQ-024 OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI on v1,imm; SLLI/SRLI/SRAI shift v1 by imm[4:0], SRAI when more_precise=1.
REQ-025 OP (0110011): same ops on v1,v2, shift amount v2[4:0]; funct3 000 with more_precise=1 -> SUB; 101 with more_precise=1 -> SRA.
REQ-026 SLT/SLTU results SHALL be 0 or 1 zero-extended; all arithmetic mod 2^32.
REQ-027 Unknown opcode: out_config=1, val=0, jump=0, target=pc+4 (ROB retires/traps).
REQ-028 out_target for non-control ops SHALL be pc+4; out_jump=0.

Reset
REQ-029 rst asserted (any time, incl. mid-operation) SHALL immediately force out_config=0, out_val=0, out_rob_entry=0, out_jump=0, out_target=0, counters=0.
REQ-030 First acceptance possible on first rising edge after rst deasserts.

Configuration
REQ-031 Macro ALU_STAT_EN defined: stat_ops increments per accepted op, stat_taken per accepted op with jump=1; both saturate at all-ones; cleared only by rst, not rollback; unchanged while rdy low.
REQ-032 ALU_STAT_EN undefined: counters and stat ports absent; all other behaviour identical.

Verification
REQ-033 ADD v1=0x7FFFFFFF,v2=1,tag 5 -> next cycle out_config=1, val=0x80000000, rob 5, jump 0, target pc+4.
REQ-034 BLT v1=0xFFFFFFFF,v2=1,pc=0x100,imm=0x20 -> jump=1, target=0x120; BLTU same operands -> jump=0, target=0x104.
REQ-035 JALR v1=0x1001,imm=4,pc=0x200 -> val=0x204, target=0x1004, jump=1.
REQ-036 SRAI v1=0x80000000, imm=0x404 (more_precise=1) -> val=0xF8000000; SRLI same (more_precise=0) -> 0x08000000.
REQ-037 Issue ops on 3 consecutive cycles, rollback on 2nd -> out_config pattern 1,0,1 (third accepted); rdy low 2 cycles mid-stream -> outputs frozen, no op lost.
REQ-038 rst pulse asynchronously mid-cycle with out_config=1 -> outputs 0 before next edge; with ALU_STAT_EN after 3 ops (1 taken branch) counters read 3/1, then 0 after rst.

Source files
------------

// File: rtl/alu_exec.sv
// Purpose     : single-issue integer ALU / branch-resolve unit for RV32I ops.
// Latency     : 1 cycle, issue accepted on edge N is broadcast after edge N.
// Backpressure: none, one op per cycle; rdy low freezes all state.
//
// Ports:
//   clk, rst (async, active-high), rdy (global enable), rollback (flush)
//   in_*   : issue bundle from the reservation station (operands, pc, imm, decode fields, tag)
//   out_*  : result broadcast (valid, value, tag, jump taken, next-pc target)
//   stat_ops / stat_taken : saturating op / taken-jump counters, only when
//                           ALU_STAT_EN is defined
module alu_exec #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic              in_config,
  input  logic [31:0]       in_value_1,
  input  logic [31:0]       in_value_2,
  input  logic [31:0]       in_value_pc,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_precise,
  input  logic              in_more_precise,
  input  logic [31:0]       in_imm,
  input  logic [3:0]        in_rob_entry,
`ifdef ALU_STAT_EN
  output logic [STAT_W-1:0] stat_ops,
  output logic [STAT_W-1:0] stat_taken,
`endif
  output logic              out_config,
  output logic [31:0]       out_val,
  output logic [3:0]        out_rob_entry,
  output logic              out_jump,
  output logic [31:0]       out_target
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Counter width must be at least one bit; an empty block trips elaboration
  // otherwise-silent misconfigurations into a visible generate scope.
  if (STAT_W < 1) begin : g_bad_stat_w
  end

  logic        accept;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] opb;
  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;
  logic        br_cond;
  logic [31:0] alu_res;
  logic [31:0] jalr_sum;
  logic [31:0] res_val;
  logic        res_jump;
  logic [31:0] res_target;

  assign accept = rdy && !rollback && in_config;

  always_comb begin
    pc_plus4    = in_value_pc + 32'd4;
    pc_plus_imm = in_value_pc + in_imm;
    jalr_sum    = in_value_1 + in_imm;
    // Second ALU operand: rs2 for register-register ops, immediate otherwise.
    opb         = (in_opcode == OPC_OP) ? in_value_2 : in_imm;
    shamt       = opb[4:0];
    lt_s        = $signed(in_value_1) < $signed(opb);
    lt_u        = in_value_1 < opb;

    // Branches always compare rs1 against rs2, independent of opb.
    br_cond = 1'b0;
    case (in_precise)
      3'b000:  br_cond = (in_value_1 == in_value_2);
      3'b001:  br_cond = (in_value_1 != in_value_2);
      3'b100:  br_cond = $signed(in_value_1) <  $signed(in_value_2);
      3'b101:  br_cond = $signed(in_value_1) >= $signed(in_value_2);
      3'b110:  br_cond = in_value_1 <  in_value_2;
      3'b111:  br_cond = in_value_1 >= in_value_2;
      default: br_cond = 1'b0;
    endcase

    alu_res = 32'd0;
    case (in_precise)
      // instr[30] selects SUB only for register-register form; ADDI ignores it.
      3'b000:  alu_res = (in_opcode == OPC_OP && in_more_precise) ? in_value_1 - opb
                                                                  : in_value_1 + opb;
      3'b001:  alu_res = in_value_1 << shamt;
      3'b010:  alu_res = {31'd0, lt_s};
      3'b011:  alu_res = {31'd0, lt_u};
      3'b100:  alu_res = in_value_1 ^ opb;
      3'b101:  alu_res = in_more_precise ? $unsigned($signed(in_value_1) >>> shamt)
                                         : in_value_1 >> shamt;
      3'b110:  alu_res = in_value_1 | opb;
      default: alu_res = in_value_1 & opb;
    endcase

    res_val    = 32'd0;
    res_jump   = 1'b0;
    res_target = pc_plus4;
    case (in_opcode)
      OPC_LUI:   res_val = in_imm;
      OPC_AUIPC: res_val = pc_plus_imm;
      OPC_JAL: begin
        res_val    = pc_plus4;
        res_jump   = 1'b1;
        res_target = pc_plus_imm;
      end
      OPC_JALR: begin
        res_val    = pc_plus4;
        res_jump   = 1'b1;
        res_target = {jalr_sum[31:1], 1'b0};
      end
      OPC_BRANCH: begin
        res_jump   = br_cond;
        res_target = br_cond ? pc_plus_imm : pc_plus4;
      end
      OPC_OPIMM, OPC_OP: res_val = alu_res;
      // Unknown opcodes still broadcast so the ROB can retire/trap the entry.
      default: res_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_config    <= 1'b0;
      out_val       <= 32'd0;
      out_rob_entry <= 4'd0;
      out_jump      <= 1'b0;
      out_target    <= 32'd0;
    end else if (rdy) begin
      out_config <= accept;
      if (accept) begin
        out_val       <= res_val;
        out_rob_entry <= in_rob_entry;
        out_jump      <= res_jump;
        out_target    <= res_target;
      end
    end
  end

`ifdef ALU_STAT_EN
  // Counters survive rollback: they count work done, not work retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_taken <= '0;
    end else if (accept) begin
      if (stat_ops != '1)
        stat_ops <= stat_ops + {{(STAT_W-1){1'b0}}, 1'b1};
      if (res_jump && stat_taken != '1)
        stat_taken <= stat_taken + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed issue sequence, expected results queued at
// issue and popped when the broadcast is due; counters checked when
// ALU_STAT_EN is defined.
module tb_alu_exec;
  localparam int STAT_W = 4;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, OPI = 7'b0010011;
  localparam logic [6:0] OP = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, in_config, in_more_precise;
  logic [31:0] in_value_1, in_value_2, in_value_pc, in_imm;
  logic [6:0]  in_opcode;
  logic [2:0]  in_precise;
  logic [3:0]  in_rob_entry;
  logic        out_config, out_jump;
  logic [31:0] out_val, out_target;
  logic [3:0]  out_rob_entry;
`ifdef ALU_STAT_EN
  logic [STAT_W-1:0] stat_ops, stat_taken;
`endif

  alu_exec #(.STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .in_config(in_config),
    .in_value_1(in_value_1), .in_value_2(in_value_2), .in_value_pc(in_value_pc),
    .in_opcode(in_opcode), .in_precise(in_precise), .in_more_precise(in_more_precise),
    .in_imm(in_imm), .in_rob_entry(in_rob_entry),
`ifdef ALU_STAT_EN
    .stat_ops(stat_ops), .stat_taken(stat_taken),
`endif
    .out_config(out_config), .out_val(out_val), .out_rob_entry(out_rob_entry),
    .out_jump(out_jump), .out_target(out_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] val;
    logic        jump;
    logic [31:0] target;
    logic [3:0]  rob;
  } res_t;

  res_t q[$];
  res_t held;
  logic exp_cfg;
  int   tests = 0;
  int   fails = 0;
  int   exp_ops = 0;
  int   exp_taken = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v == (1 << STAT_W) - 1) ? v : v + 1;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".config"}, {31'd0, out_config}, {31'd0, exp_cfg});
    chk({tag, ".val"}, out_val, held.val);
    chk({tag, ".rob"}, {28'd0, out_rob_entry}, {28'd0, held.rob});
    chk({tag, ".jump"}, {31'd0, out_jump}, {31'd0, held.jump});
    chk({tag, ".target"}, out_target, held.target);
`ifdef ALU_STAT_EN
    chk({tag, ".stat_ops"}, 32'(stat_ops), 32'(exp_ops));
    chk({tag, ".stat_taken"}, 32'(stat_taken), 32'(exp_taken));
`endif
  endtask

  // Advance one edge and compare against the scoreboard.
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (rdy) begin
      if (q.size() > 0) begin
        held      = q.pop_front();
        exp_cfg   = 1'b1;
        exp_ops   = sat_inc(exp_ops);
        if (held.jump) exp_taken = sat_inc(exp_taken);
      end else begin
        exp_cfg = 1'b0;
      end
    end
    check_outputs(tag);
  endtask

  task automatic issue(input string tag, input logic cfg, input logic rb,
                       input logic [6:0] opc, input logic [2:0] f3, input logic mp,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] tag_id,
                       input logic [31:0] ev, input logic ej, input logic [31:0] et);
    res_t r;
    in_config = cfg; rollback = rb; in_opcode = opc; in_precise = f3;
    in_more_precise = mp; in_value_1 = v1; in_value_2 = v2; in_value_pc = pc;
    in_imm = imm; in_rob_entry = tag_id;
    if (rdy && !rb && cfg) begin
      r.val = ev; r.jump = ej; r.target = et; r.rob = tag_id;
      q.push_back(r);
    end
    tick(tag);
  endtask

  // Asynchronous reset a few ns into the cycle; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    held = '0; exp_cfg = 1'b0; q.delete(); exp_ops = 0; exp_taken = 0;
    check_outputs(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b0; rollback = 1'b0; in_config = 1'b0;
    in_value_1 = '0; in_value_2 = '0; in_value_pc = '0; in_imm = '0;
    in_opcode = '0; in_precise = '0; in_more_precise = 1'b0; in_rob_entry = '0;
    held = '0; exp_cfg = 1'b0;
    #2 rst = 1'b1;
    #1 check_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    rdy = 1'b1;

    issue("add_ovf", 1, 0, OP, 3'b000, 0, 32'h7FFFFFFF, 32'd1, 32'h40, 32'd0, 4'd5,
          32'h80000000, 0, 32'h44);
    issue("blt", 1, 0, BR, 3'b100, 0, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 4'd1,
          32'd0, 1, 32'h120);
    issue("bltu", 1, 0, BR, 3'b110, 0, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 4'd2,
          32'd0, 0, 32'h104);
    issue("jalr", 1, 0, JALR, 3'b000, 0, 32'h1001, 32'd0, 32'h200, 32'd4, 4'd3,
          32'h204, 1, 32'h1004);
    issue("srai", 1, 0, OPI, 3'b101, 1, 32'h80000000, 32'd0, 32'h10, 32'h404, 4'd4,
          32'hF8000000, 0, 32'h14);
    issue("srli", 1, 0, OPI, 3'b101, 0, 32'h80000000, 32'd0, 32'h10, 32'h404, 4'd6,
          32'h08000000, 0, 32'h14);
    issue("sub", 1, 0, OP, 3'b000, 1, 32'd5, 32'd7, 32'h20, 32'd0, 4'd7,
          32'hFFFFFFFE, 0, 32'h24);
    issue("sltiu", 1, 0, OPI, 3'b011, 0, 32'd1, 32'd0, 32'h30, 32'hFFFFFFFF, 4'd8,
          32'd1, 0, 32'h34);
    issue("slti", 1, 0, OPI, 3'b010, 0, 32'd1, 32'd0, 32'h30, 32'hFFFFFFFF, 4'd9,
          32'd0, 0, 32'h34);
    issue("lui", 1, 0, LUI, 3'b000, 0, 32'd0, 32'd0, 32'h800, 32'h12345000, 4'd10,
          32'h12345000, 0, 32'h804);
    issue("auipc", 1, 0, AUIPC, 3'b000, 0, 32'd0, 32'd0, 32'h1000, 32'h2000, 4'd11,
          32'h3000, 0, 32'h1004);
    issue("jal", 1, 0, JAL, 3'b000, 0, 32'd0, 32'd0, 32'h300, 32'hFFFFFFF0, 4'd12,
          32'h304, 1, 32'h2F0);
    issue("beq", 1, 0, BR, 3'b000, 0, 32'h55, 32'h55, 32'h400, 32'h40, 4'd13,
          32'd0, 1, 32'h440);
    issue("br_f3_010", 1, 0, BR, 3'b010, 0, 32'h55, 32'h55, 32'h500, 32'h40, 4'd14,
          32'd0, 0, 32'h504);
    issue("unknown", 1, 0, 7'b0000000, 3'b000, 0, 32'h1, 32'h2, 32'h600, 32'h8, 4'd15,
          32'd0, 0, 32'h604);
    issue("idle", 0, 0, OP, 3'b000, 0, 32'h1, 32'h2, 32'h0, 32'h0, 4'd0,
          32'd0, 0, 32'd0);

    // Rollback on the middle of three back-to-back issues.
    issue("seq_a", 1, 0, OPI, 3'b000, 0, 32'd1, 32'd0, 32'h700, 32'd2, 4'd1,
          32'd3, 0, 32'h704);
    issue("seq_b_rb", 1, 1, OP, 3'b000, 0, 32'd9, 32'd9, 32'h704, 32'd0, 4'd2,
          32'd18, 0, 32'h708);
    issue("seq_c", 1, 0, OP, 3'b100, 0, 32'hF0F0, 32'hFF00, 32'h708, 32'd0, 4'd3,
          32'h0FF0, 0, 32'h70C);

    // rdy low for two edges: broadcast and counters freeze, op E re-presented.
    issue("frz_d", 1, 0, OP, 3'b110, 0, 32'h1, 32'h2, 32'h710, 32'd0, 4'd4,
          32'h3, 0, 32'h714);
    rdy = 1'b0;
    issue("frz_1", 1, 0, OP, 3'b111, 0, 32'hFF, 32'h0F, 32'h720, 32'd0, 4'd6,
          32'h0F, 0, 32'h724);
    issue("frz_2", 1, 0, OP, 3'b111, 0, 32'hFF, 32'h0F, 32'h720, 32'd0, 4'd6,
          32'h0F, 0, 32'h724);
    rdy = 1'b1;
    issue("frz_e", 1, 0, OP, 3'b111, 0, 32'hFF, 32'h0F, 32'h720, 32'd0, 4'd6,
          32'h0F, 0, 32'h724);

    async_reset("rst_mid1");
    issue("post_add", 1, 0, OP, 3'b000, 0, 32'd2, 32'd3, 32'h900, 32'd0, 4'd7,
          32'd5, 0, 32'h904);
    issue("post_beq", 1, 0, BR, 3'b000, 0, 32'd4, 32'd4, 32'h904, 32'h10, 4'd8,
          32'd0, 1, 32'h914);
    issue("post_addi", 1, 0, OPI, 3'b000, 0, 32'd10, 32'd0, 32'h908, 32'hFFFFFFFF, 4'd9,
          32'd9, 0, 32'h90C);
    async_reset("rst_mid2");
    issue("after_rst_idle", 0, 0, OP, 3'b000, 0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0,
          32'd0, 0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
